// File: rtl/pll_md_arbiter.sv
// pll_md_arbiter: round-robin arbiter of two requesters onto a PLL management (MD) port.
// Define PLL_MD_READBACK_EN to verify every write by reading it back (sets sticky rb_err on mismatch).
module pll_md_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        mdclk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [1:0]  ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        rb_err,
    output logic [1:0]  mdopc,
    output logic        mdainc,
    output logic [7:0]  mdwdi,
    input  logic [7:0]  mdrdo
);
    localparam logic [1:0] OP_NOP = 2'b00, OP_LD = 2'b01, OP_WR = 2'b10, OP_RD = 2'b11;
`ifdef PLL_MD_READBACK_EN
    typedef enum logic [2:0] {IDLE, ADDR, XFER, WAIT, DONE, RB_RD, RB_WAIT} state_t;
    logic rb_err_q;
`else
    typedef enum logic [2:0] {IDLE, ADDR, XFER, WAIT, DONE} state_t;
`endif
    state_t      state_q;
    logic        grant_q, prio_q, we_q;
    logic [7:0]  addr_q, wdata_q, rdata_q, mdwdi_q;
    logic [2:0]  cnt_q;
    logic [1:0]  ack_q, mdopc_q, ack_d;
    logic        grant_d;
    // prio_q names the requester that wins a tie
    assign grant_d = (&req) ? prio_q : req[1];
    assign ack_d   = 2'b01 << grant_q;
    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            prio_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            mdopc_q  <= OP_NOP;
            mdwdi_q  <= '0;
`ifdef PLL_MD_READBACK_EN
            rb_err_q <= 1'b0;
`endif
        end else begin
            ack_q   <= '0;
            mdopc_q <= OP_NOP;
            mdwdi_q <= '0;
            case (state_q)
                IDLE: if (|req) begin
                    grant_q <= grant_d;
                    we_q    <= we[grant_d];
                    addr_q  <= grant_d ? addr[15:8] : addr[7:0];
                    wdata_q <= grant_d ? wdata[15:8] : wdata[7:0];
                    mdopc_q <= OP_LD;
                    mdwdi_q <= grant_d ? addr[15:8] : addr[7:0];
                    state_q <= ADDR;
                end
                ADDR: begin
                    mdopc_q <= we_q ? OP_WR : OP_RD;
                    mdwdi_q <= we_q ? wdata_q : 8'h00;
                    cnt_q   <= 3'(RD_LAT - 1);
                    state_q <= XFER;
                end
                XFER: begin
                    if (!we_q) begin
                        state_q <= WAIT;
                    end else begin
`ifdef PLL_MD_READBACK_EN
                        mdopc_q <= OP_RD;
                        state_q <= RB_RD;
`else
                        ack_q   <= ack_d;
                        state_q <= DONE;
`endif
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        rdata_q <= mdrdo;
                        ack_q   <= ack_d;
                        state_q <= DONE;
                    end
                end
`ifdef PLL_MD_READBACK_EN
                RB_RD: begin
                    cnt_q   <= 3'(RD_LAT - 1);
                    state_q <= RB_WAIT;
                end
                RB_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        rb_err_q <= rb_err_q | (mdrdo != wdata_q);
                        ack_q    <= ack_d;
                        state_q  <= DONE;
                    end
                end
`endif
                DONE: begin
                    prio_q  <= ~grant_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign busy   = state_q != IDLE;
    assign mdopc  = mdopc_q;
    assign mdwdi  = mdwdi_q;
    assign mdainc = 1'b0;
`ifdef PLL_MD_READBACK_EN
    assign rb_err = rb_err_q;
`else
    assign rb_err = 1'b0;
`endif
endmodule

// File: tb/tb_pll_md_arbiter.sv
// tb_pll_md_arbiter: randomized transaction bench with a PLL register-file model and a transaction-level reference.
module tb_pll_md_arbiter;
    localparam int RD_LAT = 2;
    logic        mdclk = 1'b0;
    logic        reset;
    logic [1:0]  req, we, ack, mdopc;
    logic [15:0] addr, wdata;
    logic [7:0]  rdata, mdwdi, mdrdo;
    logic        busy, rb_err, mdainc;
    int          n_vec = 0, n_err = 0;
    logic [7:0]  pmem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  pla = 8'h00;
    int          rcnt = 0;
    bit          corrupt = 1'b0;
    bit          prio = 1'b0;
    bit          exp_rb = 1'b0;
    logic [7:0]  exp_rdata = 8'h00;

    pll_md_arbiter #(.RD_LAT(RD_LAT)) dut (
        .mdclk(mdclk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .rb_err(rb_err), .mdopc(mdopc),
        .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo)
    );

    always #5 mdclk = ~mdclk;

    // PLL model: read data appears RD_LAT cycles after the read opcode and is junk otherwise
    always @(negedge mdclk) begin
        if (mdopc == 2'b01) pla = mdwdi;
        if (mdopc == 2'b10) pmem[pla] = mdwdi;
        if (rcnt > 0) rcnt--;
        if (mdopc == 2'b11) rcnt = RD_LAT + 1;
        mdrdo = (rcnt == 1) ? (pmem[pla] ^ {7'd0, corrupt}) : 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mdclk);
        #1;
    endtask

    task automatic txn(input logic [1:0] r, input logic [1:0] w, input logic [15:0] a,
                       input logic [15:0] d, input bit hold);
        int win, lat, k;
        bit iw;
        logic [7:0] wa, wd;
        req = r; we = w; addr = a; wdata = d;
        win = (r == 2'b11) ? int'(prio) : (r[1] ? 1 : 0);
        iw  = w[win];
        wa  = a[win*8 +: 8];
        wd  = d[win*8 +: 8];
        lat = iw ? 3 : 3 + RD_LAT;
`ifdef PLL_MD_READBACK_EN
        if (iw) lat = 4 + RD_LAT;
`endif
        step(); k = 1;
        check("busy_on", busy, 1);
        check("addr_opc", mdopc, 2'b01);
        check("addr_bus", mdwdi, wa);
        if (!hold) req = 2'b00;
        step(); k = 2;
        check("xfer_opc", mdopc, iw ? 2'b10 : 2'b11);
        check("xfer_bus", mdwdi, iw ? wd : 8'h00);
        while (ack == 2'b00 && k < 30) begin
            step(); k++;
            if (!iw) begin
                check("wait_opc", mdopc, 2'b00);
                check("wait_bus", mdwdi, 8'h00);
            end
        end
        if (iw) begin
            ref_mem[wa] = wd;
            if (corrupt) exp_rb = 1'b1;
        end else begin
            exp_rdata = ref_mem[wa];
        end
        prio = (win == 0);
        check("ack_lat", k, lat);
        check("ack", ack, 32'(1) << win);
        check("rdata", rdata, exp_rdata);
        check("rb_err", rb_err, exp_rb);
        step();
        check("ack_clr", ack, 2'b00);
        check("idle", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            pmem[i] = 8'($urandom);
            ref_mem[i] = pmem[i];
        end
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        step(); step();
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_rberr", rb_err, 0);
        check("rst_opc", mdopc, 0);
        check("rst_bus", mdwdi, 0);
        check("mdainc", mdainc, 0);
        reset = 1'b0;
        step();
        txn(2'b01, 2'b01, 16'h0012, 16'h00A5, 1'b0);
        pmem[7] = 8'h3C; ref_mem[7] = 8'h3C;
        txn(2'b10, 2'b00, 16'h0700, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++)
            txn(2'b11, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        req = 2'b00;
        step();
        for (int i = 0; i < 40; i++) begin
            txn(2'($urandom_range(1, 3)), 2'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) step();
        end
        // reset in the middle of a read wait: no ack, back to requester-0 priority
        req = 2'b10; we = 2'b00; addr = 16'h2200;
        step(); req = 2'b00; step(); step();
        check("mid_wait", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_opc", mdopc, 0);
        check("abort_ack", ack, 0);
        check("abort_rdata", rdata, 0);
        prio = 1'b0; exp_rdata = 8'h00; exp_rb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_noack", ack, 0);
        end
        txn(2'b11, 2'b00, 16'h3344, 16'h0000, 1'b0);
        txn(2'b11, 2'b11, 16'h5566, 16'h7788, 1'b0);
`ifdef PLL_MD_READBACK_EN
        corrupt = 1'b1;
        txn(2'b01, 2'b01, 16'h0030, 16'h0055, 1'b0);
        corrupt = 1'b0;
        for (int i = 0; i < 4; i++)
            txn(2'($urandom_range(1, 3)), 2'b11, 16'($urandom), 16'($urandom), 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rb_clr", rb_err, 0);
        prio = 1'b0; exp_rdata = 8'h00; exp_rb = 1'b0;
        txn(2'b01, 2'b01, 16'h0031, 16'h0066, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
